// File: rtl/ov5640_dvp_pkg.sv
// Shared types and constants for the OV5640 DVP test-pattern transmitter.
// The optional frame CRC (enabled by DVP_TX_CRC_EN) uses the CRC helpers below.
package ov5640_dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_VSYNC    = 3'd1,
        ST_VBP      = 3'd2,
        ST_ACT_LINE = 3'd3,
        ST_H_BLANK  = 3'd4,
        ST_VFP      = 3'd5
    } dvp_tx_state_e;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_SOLID   = 2'd3
    } dvp_pattern_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // White, yellow, cyan, green, magenta, red, blue, black
    localparam rgb565_t COLOUR_BARS [8] = '{
        rgb565_t'(16'hFFFF), rgb565_t'(16'hFFE0), rgb565_t'(16'h07FF), rgb565_t'(16'h07E0),
        rgb565_t'(16'hF81F), rgb565_t'(16'hF800), rgb565_t'(16'h001F), rgb565_t'(16'h0000)
    };

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // CRC-16-CCITT, one byte, MSB first, no reflection
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ CRC16_POLY) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/ov5640_pattern_pixel.sv
// Combinational pattern generator: maps (x, y, pattern, frame count) to one RGB565 pixel.
module ov5640_pattern_pixel
    import ov5640_dvp_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int XW       = $clog2(2 * H_ACTIVE)
) (
    input  logic [XW-1:0] x,
    input  logic [5:0]    y,
    input  dvp_pattern_e  pattern,
    input  logic [5:0]    frame_lsb,
    output rgb565_t       px
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [XW-1:0] bar_full;
    logic [2:0]    bar_sel;
    logic [5:0]    x6;

    // Widths not divisible by 8 leave a few trailing pixels; they stay in the last bar.
    assign bar_full = x / XW'(BAR_W);
    assign bar_sel  = (bar_full > XW'(7)) ? 3'd7 : bar_full[2:0];
    assign x6       = 6'(x);

    always_comb begin
        px = '0;
        case (pattern)
            PAT_BARS:    px = COLOUR_BARS[bar_sel];
            PAT_RAMP:    px = '{r: x6[4:0], g: x6, b: y[4:0]};
            PAT_CHECKER: px = (x6[5] ^ y[5]) ? rgb565_t'(16'hFFFF) : rgb565_t'(16'h0000);
            PAT_SOLID:   px = '{r: frame_lsb[4:0], g: frame_lsb, b: frame_lsb[4:0]};
            default:     px = '0;
        endcase
    end

endmodule

// File: rtl/ov5640_dvp_pattern_tx.sv
// OV5640 DVP emulator: vsync/href framing with RGB565 test patterns, two bytes per pixel.
// Define DVP_TX_CRC_EN to add a per-frame CRC-16-CCITT over all href bytes (crc16/crc_valid).
//
// state    | meaning
// IDLE     | outputs low, waiting for enable
// VSYNC    | vsync high for VSYNC_LINES line periods
// VBP      | vertical back porch, VBP_LINES line periods
// ACT_LINE | href high, 2*H_ACTIVE bytes of one line
// H_BLANK  | href low for H_BLANK clocks after each line
// VFP      | vertical front porch, VFP_LINES line periods
module ov5640_dvp_pattern_tx
    import ov5640_dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 160,
    parameter int VSYNC_LINES = 4,
    parameter int VBP_LINES   = 16,
    parameter int VFP_LINES   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_start,
    output logic [7:0]  frame_cnt,
    output logic        busy
`ifdef DVP_TX_CRC_EN
    ,
    output logic [15:0] crc16,
    output logic        crc_valid
`endif
);

    localparam int ACT_CLKS   = 2 * H_ACTIVE;
    localparam int LINE_CLKS  = ACT_CLKS + H_BLANK;
    localparam int VSYNC_CLKS = VSYNC_LINES * LINE_CLKS;
    localparam int VBP_CLKS   = VBP_LINES * LINE_CLKS;
    localparam int VFP_CLKS   = VFP_LINES * LINE_CLKS;
    localparam int TMR_MAX    = max_int(max_int(VSYNC_CLKS, VBP_CLKS), max_int(VFP_CLKS, ACT_CLKS));
    localparam int TMR_W      = $clog2(TMR_MAX + 1);
    localparam int BW         = $clog2(ACT_CLKS);
    localparam int YW         = $clog2(V_ACTIVE + 1);

    dvp_tx_state_e state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [BW-1:0]    byte_cnt, byte_nxt;
    logic [YW-1:0]    y_cnt, y_nxt;
    dvp_pattern_e     pattern_q;
    logic             tmr_tc;
    logic             frame_begin;
    logic             frame_end;
    rgb565_t          px;

    assign tmr_tc      = (tmr == '0);
    assign frame_begin = (state_nxt == ST_VSYNC) && (state != ST_VSYNC);
    assign frame_end   = (state == ST_VFP) && tmr_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tmr      <= '0;
            byte_cnt <= '0;
            y_cnt    <= '0;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            byte_cnt <= byte_nxt;
            y_cnt    <= y_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr_tc ? tmr : tmr - 1'b1;
        byte_nxt  = byte_cnt;
        y_nxt     = y_cnt;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_VSYNC;
                    tmr_nxt   = TMR_W'(VSYNC_CLKS - 1);
                end
            end
            ST_VSYNC: begin
                if (tmr_tc) begin
                    state_nxt = ST_VBP;
                    tmr_nxt   = TMR_W'(VBP_CLKS - 1);
                end
            end
            ST_VBP: begin
                if (tmr_tc) begin
                    state_nxt = ST_ACT_LINE;
                    tmr_nxt   = TMR_W'(ACT_CLKS - 1);
                    byte_nxt  = '0;
                    y_nxt     = '0;
                end
            end
            ST_ACT_LINE: begin
                if (tmr_tc) begin
                    state_nxt = ST_H_BLANK;
                    tmr_nxt   = TMR_W'(H_BLANK - 1);
                end else begin
                    byte_nxt  = byte_cnt + 1'b1;
                end
            end
            ST_H_BLANK: begin
                if (tmr_tc) begin
                    if (y_cnt == YW'(V_ACTIVE - 1)) begin
                        state_nxt = ST_VFP;
                        tmr_nxt   = TMR_W'(VFP_CLKS - 1);
                    end else begin
                        state_nxt = ST_ACT_LINE;
                        tmr_nxt   = TMR_W'(ACT_CLKS - 1);
                        byte_nxt  = '0;
                        y_nxt     = y_cnt + 1'b1;
                    end
                end
            end
            ST_VFP: begin
                // A deasserted enable is only honoured here, so frames are never cut short.
                if (tmr_tc) begin
                    if (enable) begin
                        state_nxt = ST_VSYNC;
                        tmr_nxt   = TMR_W'(VSYNC_CLKS - 1);
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tmr_nxt   = '0;
            end
        endcase
    end

    // Fed with next-cycle coordinates so the registered byte lines up with registered href.
    ov5640_pattern_pixel #(
        .H_ACTIVE (H_ACTIVE),
        .XW       (BW)
    ) u_pixel (
        .x         (byte_nxt >> 1),
        .y         (6'(y_nxt)),
        .pattern   (pattern_q),
        .frame_lsb (frame_cnt[5:0]),
        .px        (px)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q   <= PAT_BARS;
            frame_cnt   <= '0;
            dvp_vsync   <= 1'b0;
            dvp_href    <= 1'b0;
            dvp_data    <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (frame_begin) begin
                pattern_q <= dvp_pattern_e'(pattern_sel);
            end
            if (frame_end) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            dvp_vsync   <= (state_nxt == ST_VSYNC);
            dvp_href    <= (state_nxt == ST_ACT_LINE);
            frame_start <= frame_begin;
            busy        <= (state_nxt != ST_IDLE);
            if (state_nxt == ST_ACT_LINE) begin
                dvp_data <= byte_nxt[0] ? {px.g[2:0], px.b} : {px.r, px.g[5:3]};
            end else begin
                dvp_data <= 8'h00;
            end
        end
    end

`ifdef DVP_TX_CRC_EN
    logic [15:0] crc_acc;
    logic        vfp_entry;

    assign vfp_entry = (state_nxt == ST_VFP) && (state != ST_VFP);

    // Accumulates from the registered DVP bytes, so it is settled well before VFP is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_acc   <= CRC16_INIT;
            crc16     <= '0;
            crc_valid <= 1'b0;
        end else begin
            if (frame_begin) begin
                crc_acc <= CRC16_INIT;
            end else if (dvp_href) begin
                crc_acc <= crc16_byte(crc_acc, dvp_data);
            end
            crc_valid <= vfp_entry;
            if (vfp_entry) begin
                crc16 <= crc_acc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ov5640_dvp_pattern_tx.sv
// Self-checking bench for ov5640_dvp_pattern_tx at an 8x4 frame; frame-position reference model.
module tb_ov5640_dvp_pattern_tx;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int HB    = 4;
    localparam int LINE  = 2 * H + HB;
    localparam int VS_END  = 1 * LINE;
    localparam int ACT_BEG = VS_END + 1 * LINE;
    localparam int ACT_END = ACT_BEG + V * LINE;
    localparam int FRAME   = ACT_END + 1 * LINE;

    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    localparam logic [7:0] LINE0_BARS [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                               8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] pattern_sel;
    logic       dvp_vsync, dvp_href, frame_start, busy;
    logic [7:0] dvp_data, frame_cnt;
`ifdef DVP_TX_CRC_EN
    logic [15:0] crc16;
    logic        crc_valid;
`endif

    int errors = 0;
    int checks = 0;

    ov5640_dvp_pattern_tx #(
        .H_ACTIVE (H), .V_ACTIVE (V), .H_BLANK (HB),
        .VSYNC_LINES (1), .VBP_LINES (1), .VFP_LINES (1)
    ) dut (
        .clk (clk), .rst_n (rst_n), .enable (enable), .pattern_sel (pattern_sel),
        .dvp_vsync (dvp_vsync), .dvp_href (dvp_href), .dvp_data (dvp_data),
        .frame_start (frame_start), .frame_cnt (frame_cnt), .busy (busy)
`ifdef DVP_TX_CRC_EN
        , .crc16 (crc16), .crc_valid (crc_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: position within the frame ----------------
    function automatic logic [15:0] exp_pix(input int x, input int y, input int sel, input int fc);
        int r, g, b;
        case (sel)
            0: return BARS[x / (H / 8)];
            1: begin r = x % 32; g = x % 64; b = y % 32; end
            2: return ((((x / 32) % 2) ^ ((y / 32) % 2)) != 0) ? 16'hFFFF : 16'h0000;
            default: begin r = fc % 32; g = fc % 64; b = fc % 32; end
        endcase
        return 16'(r * 2048 + g * 32 + b);
    endfunction

    function automatic bit href_at(input int p);
        return (p >= ACT_BEG) && (p < ACT_END) && (((p - ACT_BEG) % LINE) < 2 * H);
    endfunction

    function automatic logic [7:0] exp_byte(input int p, input int sel, input int fc);
        int q, c;
        logic [15:0] pix;
        if (!href_at(p)) return 8'h00;
        q   = p - ACT_BEG;
        c   = q % LINE;
        pix = exp_pix(c / 2, q / LINE, sel, fc);
        return (c % 2 == 1) ? pix[7:0] : pix[15:8];
    endfunction

    function automatic logic [15:0] crc_bits(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        logic fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    int          m_pos = -1;
    int          m_fc  = 0;
    int          m_sel = 0;
    logic [15:0] m_crc_run = 16'hFFFF;
    logic [15:0] m_crc = 16'h0000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = -1; m_fc = 0; m_sel = 0;
            m_crc_run = 16'hFFFF; m_crc = 16'h0000;
        end else begin
            if (href_at(m_pos)) m_crc_run = crc_bits(m_crc_run, exp_byte(m_pos, m_sel, m_fc));
            if (m_pos == -1) begin
                if (enable) begin m_pos = 0; m_sel = int'(pattern_sel); end
            end else if (m_pos == FRAME - 1) begin
                m_fc = (m_fc + 1) % 256;
                if (enable) begin m_pos = 0; m_sel = int'(pattern_sel); end
                else m_pos = -1;
            end else begin
                m_pos++;
            end
            if (m_pos == 0) m_crc_run = 16'hFFFF;
            if (m_pos == ACT_END) m_crc = m_crc_run;
        end
    end

    logic cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("vsync", 32'(dvp_vsync), 32'(m_pos >= 0 && m_pos < VS_END));
            check("href", 32'(dvp_href), 32'(href_at(m_pos)));
            check("data", 32'(dvp_data), 32'(exp_byte(m_pos, m_sel, m_fc)));
            check("frame_start", 32'(frame_start), 32'(m_pos == 0));
            check("frame_cnt", 32'(frame_cnt), 32'(m_fc));
            check("busy", 32'(busy), 32'(m_pos >= 0));
`ifdef DVP_TX_CRC_EN
            check("crc_valid", 32'(crc_valid), 32'(m_pos == ACT_END));
            check("crc16", 32'(crc16), 32'(m_crc));
`endif
        end
    end

    // ---------------- frame measurement helpers ----------------
    int m_period, m_vs, m_pulses, m_hhi, m_nz, m_blank_bad, m_cv;
    logic [7:0] m_line0 [16];

    task automatic wait_fs(input int limit);
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("frame_start_timeout", 32'(n < limit), 32'd1);
    endtask

    // Starts on a frame_start cycle, returns on the next one.
    task automatic measure_frame();
        logic prev_h;
        int   nb;
        prev_h = 1'b0; nb = 0;
        m_period = 0; m_vs = 0; m_pulses = 0; m_hhi = 0; m_nz = 0; m_blank_bad = 0; m_cv = 0;
        do begin
            if (dvp_vsync) m_vs++;
            if (dvp_href) begin
                m_hhi++;
                if (!prev_h) m_pulses++;
                if (nb < 16) begin m_line0[nb] = dvp_data; nb++; end
                if (dvp_data != 8'h00) m_nz++;
            end else if (dvp_data != 8'h00) begin
                m_blank_bad++;
            end
`ifdef DVP_TX_CRC_EN
            if (crc_valid) m_cv++;
`endif
            prev_h = dvp_href;
            @(negedge clk);
            m_period++;
        end while (frame_start !== 1'b1 && m_period < 1000);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, ff_seen, hhi, vs_cnt;
        rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_vsync", 32'(dvp_vsync), 32'd0);
        check("rst_href", 32'(dvp_href), 32'd0);
        check("rst_data", 32'(dvp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Framing and colour bars
        @(negedge clk);
        enable = 1'b1; pattern_sel = 2'd0;
        wait_fs(20);
        measure_frame();
        check("frame_period", 32'(m_period), 32'd140);
        check("vsync_width", 32'(m_vs), 32'd20);
        check("href_pulses", 32'(m_pulses), 32'd4);
        check("href_cycles", 32'(m_hhi), 32'd64);
        check("blank_data", 32'(m_blank_bad), 32'd0);
        check("frame_cnt_after_1", 32'(frame_cnt), 32'd1);
        for (int i = 0; i < 16; i++) check($sformatf("bars_byte%0d", i), 32'(m_line0[i]), 32'(LINE0_BARS[i]));

        // Pattern change mid-frame takes effect on the next frame only
        repeat (50) @(negedge clk);
        pattern_sel = 2'd2;
        ff_seen = 0; n = 0;
        while (frame_start !== 1'b1 && n < 300) begin
            if (dvp_href && dvp_data == 8'hFF) ff_seen++;
            @(negedge clk);
            n++;
        end
        check("bars_kept_after_sel_change", 32'(ff_seen > 0), 32'd1);
        measure_frame();
        check("checker_all_zero", 32'(m_nz), 32'd0);
        check("checker_href_pulses", 32'(m_pulses), 32'd4);

        // Randomised pattern and enable activity against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) pattern_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) enable = ~enable;
        end
        enable = 1'b1;

        // enable dropped during line 1: frame completes, then idle
        wait_fs(400);
        repeat (ACT_BEG + LINE + 5) @(negedge clk);
        enable = 1'b0;
        n = 0; hhi = 0;
        while (busy && n < 300) begin
            if (dvp_href) hhi++;
            @(negedge clk);
            n++;
        end
        check("drop_remaining_href", 32'(hhi), 32'd43);
        check("drop_busy_fall", 32'(n), 32'd75);
        vs_cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (dvp_vsync || busy) vs_cnt++;
        end
        check("idle_no_vsync", 32'(vs_cnt), 32'd0);

        // Asynchronous reset mid-line
        enable = 1'b1;
        wait_fs(20);
        repeat (45) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vsync", 32'(dvp_vsync), 32'd0);
        check("arst_href", 32'(dvp_href), 32'd0);
        check("arst_data", 32'(dvp_data), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_fs(10);
        check("restart_vsync", 32'(dvp_vsync), 32'd1);
        measure_frame();
        check("restart_period", 32'(m_period), 32'd140);
        check("restart_href_pulses", 32'(m_pulses), 32'd4);
        check("restart_frame_cnt", 32'(frame_cnt), 32'd1);

`ifdef DVP_TX_CRC_EN
        // Solid pattern at frame_cnt 0: CRC over 64 zero bytes
        @(negedge clk);
        rst_n = 1'b0; pattern_sel = 2'd3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_fs(10);
        measure_frame();
        check("crc_zero_bytes", 32'(m_nz), 32'd0);
        check("crc_valid_pulses", 32'(m_cv), 32'd1);
`endif

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
